// File: rtl/frame_loader.sv
// Raster-order frame loader: accepts WIDTH*HEIGHT pixels into a frame RAM write port.
// Latency: RAM write (wrEn/wrAddr/wrData) registered, one cycle after pixel acceptance.
// Backpressure: pixReady high only in LOAD; source holds its pixel while pixReady=0.
// Optional: define FRAME_BORDER_CLEAR_EN to write 0 for every border pixel.
module frame_loader #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6,
  parameter int COLSZ  = 3,
  parameter int XSZ    = 3,
  parameter int YSZ    = 3,
  parameter int ADDRSZ = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pixValid,
  input  logic [COLSZ-1:0]  pixIn,
  output logic              pixReady,
  output logic              wrEn,
  output logic [ADDRSZ-1:0] wrAddr,
  output logic [COLSZ-1:0]  wrData,
  output logic [XSZ-1:0]    curX,
  output logic [YSZ-1:0]    curY,
  output logic              busy,
  output logic              frameDone
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [XSZ-1:0] XLAST = XSZ'(WIDTH - 1);
  localparam logic [YSZ-1:0] YLAST = YSZ'(HEIGHT - 1);

  state_t             state, stateNext;
  logic               accept;
  logic               lastX, lastY;
  logic [ADDRSZ-1:0]  xExt, yExt, pixAddr;
  logic [COLSZ-1:0]   pixData;

  assign lastX  = (curX == XLAST);
  assign lastY  = (curY == YLAST);
  assign accept = pixReady && pixValid;

  // State register; reset drops straight to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    stateNext = state;
    pixReady  = 1'b0;
    busy      = 1'b0;
    frameDone = 1'b0;
    case (state)
      IDLE: if (start) stateNext = LOAD;
      LOAD: begin
        pixReady = 1'b1;
        busy     = 1'b1;
        if (accept && lastX && lastY) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        frameDone = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Raster coordinate counters: cleared on arm and after the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      curX <= '0;
      curY <= '0;
    end else if (state == IDLE && start) begin
      curX <= '0;
      curY <= '0;
    end else if (accept) begin
      if (lastX) begin
        curX <= '0;
        curY <= lastY ? '0 : curY + 1'b1;
      end else begin
        curX <= curX + 1'b1;
      end
    end
  end

  assign xExt = ADDRSZ'(curX);
  assign yExt = ADDRSZ'(curY);

  // Row-major address; the 6-wide case avoids a multiplier with shift-and-add.
  generate
    if (WIDTH == 6) begin : gAddrShift
      assign pixAddr = (yExt << 2) + (yExt << 1) + xExt;
    end else begin : gAddrMul
      assign pixAddr = yExt * ADDRSZ'(WIDTH) + xExt;
    end
  endgenerate

`ifdef FRAME_BORDER_CLEAR_EN
  // Border pixels are blackened so downstream edge searches always terminate.
  assign pixData = (curX == '0 || lastX || curY == '0 || lastY) ? '0 : pixIn;
`else
  assign pixData = pixIn;
`endif

  // Registered RAM write port, one cycle behind acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      wrEn <= accept;
      if (accept) begin
        wrAddr <= pixAddr;
        wrData <= pixData;
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader against a pixel-index reference model.
module tb_frame_loader;

  localparam int W = 6;
  localparam int H = 6;
  localparam int NPIX = W * H;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       pixValid;
  logic [2:0] pixIn;
  logic       pixReady, wrEn, busy, frameDone;
  logic [5:0] wrAddr;
  logic [2:0] wrData;
  logic [2:0] curX, curY;

  frame_loader dut (
    .clk(clk), .resetn(resetn), .start(start), .pixValid(pixValid), .pixIn(pixIn),
    .pixReady(pixReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .curX(curX), .curY(curY), .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int mState  = M_IDLE;
  int mCount  = 0;
  int dutWrites = 0;
  int frames  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int expData(input int n, input int pix);
`ifdef FRAME_BORDER_CLEAR_EN
    int x, y;
    x = n % W;
    y = n / W;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
`endif
    return pix;
  endfunction

  // One clock: advance the model from pre-edge inputs, then compare outputs.
  task automatic step();
    int expWr, expA, expD;
    @(posedge clk);
    expWr = (mState == M_LOAD && pixValid) ? 1 : 0;
    expA  = mCount;
    expD  = expData(mCount, int'(pixIn));
    case (mState)
      M_IDLE: if (start) begin mState = M_LOAD; mCount = 0; end
      M_LOAD: if (pixValid) begin
        mCount++;
        if (mCount == NPIX) begin mState = M_DONE; mCount = 0; end
      end
      default: mState = M_IDLE;
    endcase
    #1;
    check("wrEn", int'(wrEn), expWr);
    if (expWr == 1) begin
      check("wrAddr", int'(wrAddr), expA);
      check("wrData", int'(wrData), expD);
    end
    if (wrEn) dutWrites++;
    check("pixReady", int'(pixReady), (mState == M_LOAD) ? 1 : 0);
    check("busy", int'(busy), (mState != M_IDLE) ? 1 : 0);
    check("frameDone", int'(frameDone), (mState == M_DONE) ? 1 : 0);
    check("curX", int'(curX), mCount % W);
    check("curY", int'(curY), mCount / W);
    if (frameDone) begin
      check("frameWrites", dutWrites, NPIX);
      check("lastAddr", int'(wrAddr), NPIX - 1);
      dutWrites = 0;
      frames++;
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_wrEn"}, int'(wrEn), 0);
    check({tag, "_wrAddr"}, int'(wrAddr), 0);
    check({tag, "_wrData"}, int'(wrData), 0);
    check({tag, "_curX"}, int'(curX), 0);
    check({tag, "_curY"}, int'(curY), 0);
    check({tag, "_pixReady"}, int'(pixReady), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frameDone"}, int'(frameDone), 0);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic midReset();
    resetn = 1'b0;
    #2;
    checkResetState("midRst");
    mState = M_IDLE;
    mCount = 0;
    dutWrites = 0;
    #2;
    resetn = 1'b1;
  endtask

  // Arm, then stream a full frame; gap=1 toggles pixValid, fixed>=0 forces pixIn.
  task automatic runFrame(input bit gap, input int fixed);
    int sent;
    start = 1'b1; pixValid = 1'b0;
    step();
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 200 && sent < NPIX; c++) begin
      pixValid = gap ? ~c[0] : 1'b1;
      pixIn = (fixed >= 0) ? 3'(fixed) : 3'(sent % 8);
      if (pixValid) sent++;
      step();
    end
    check("frameSent", sent, NPIX);
    pixValid = 1'b0;
    for (int c = 0; c < 3; c++) step();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; pixValid = 1'b0; pixIn = '0;
    #3;
    checkResetState("rst");
    #4;
    resetn = 1'b1;
    step();

    runFrame(1'b0, -1);
    runFrame(1'b1, -1);
    runFrame(1'b0, 7);

    // Reset after 10 accepted pixels, then reload from address 0.
    start = 1'b1; step(); start = 1'b0;
    pixValid = 1'b1;
    for (int c = 0; c < 50 && mCount < 10; c++) begin
      pixIn = 3'($urandom_range(0, 7));
      step();
    end
    check("tenAccepted", mCount, 10);
    midReset();
    pixValid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    runFrame(1'b0, -1);

    // Random traffic: stray start/pixValid in every state, long start holds.
    for (int c = 0; c < 1500; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      pixValid = ($urandom_range(0, 3) != 0);
      pixIn    = 3'($urandom_range(0, 7));
      step();
    end
    start = 1'b1;
    pixValid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      pixIn = 3'($urandom_range(0, 7));
      step();
    end
    start = 1'b0; pixValid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("framesSeen", int'(frames >= 6), 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
